button_step_ctrl: RTL and testbench

BUTTON_STEP_CTRL -- requirements
Module: button_step_ctrl

---
 rtl/button_step_ctrl.sv | 113 +++++++++++
 tb/tb_button_step_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/button_step_ctrl.sv
// Button step controller: turns a debounced button level into one advance strobe per press,
// followed by auto-repeat strobes while the button stays held, and tracks the message position.
module button_step_ctrl #(
   parameter int unsigned HOLD_CYCLES   = 8,
   parameter int unsigned REPEAT_CYCLES = 4,
   parameter int unsigned MSG_LEN       = 16,
   parameter int unsigned IDX_W         = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             btn_debounc,
   output logic             step_pulse,
   output logic [IDX_W-1:0] char_index,
   output logic             held
);

   localparam int unsigned MAX_CNT = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int unsigned CNT_W   = $clog2(MAX_CNT);

   typedef enum logic [1:0] {
      S_LOCK    = 2'd0,
      S_IDLE    = 2'd1,
      S_PRESSED = 2'd2,
      S_REPEAT  = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic               r_step_pulse;
   logic               w_pulse_nxt;
   logic [IDX_W-1:0]   r_char_index;
   logic [IDX_W-1:0]   w_idx_nxt;
   logic               r_held;
   logic               w_held_nxt;

   // Next state, hold/repeat counter and pulse decision; release always wins over a terminal count.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_pulse_nxt = 1'b0;
      w_idx_nxt   = r_char_index;
      w_held_nxt  = 1'b0;

      case (r_state)
         S_LOCK: begin
            if (!btn_debounc) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_IDLE: begin
            if (btn_debounc) begin
               w_state_nxt = S_PRESSED;
               w_cnt_nxt   = '0;
               w_pulse_nxt = 1'b1;
            end
         end
         S_PRESSED: begin
            if (!btn_debounc) begin
               w_state_nxt = S_IDLE;
            end else if (r_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
               w_state_nxt = S_REPEAT;
               w_cnt_nxt   = '0;
               w_pulse_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         S_REPEAT: begin
            if (!btn_debounc) begin
               w_state_nxt = S_IDLE;
            end else if (r_cnt == CNT_W'(REPEAT_CYCLES - 1)) begin
               w_cnt_nxt   = '0;
               w_pulse_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = S_LOCK;
            w_cnt_nxt   = '0;
         end
      endcase

      if (w_pulse_nxt) begin
         w_idx_nxt = (r_char_index == IDX_W'(MSG_LEN - 1)) ? '0 : r_char_index + IDX_W'(1);
      end
      w_held_nxt = (w_state_nxt == S_REPEAT);
   end

   // State and registered outputs; reset drops into LOCK so a held button cannot fire.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_LOCK;
         r_cnt        <= '0;
         r_step_pulse <= 1'b0;
         r_char_index <= '0;
         r_held       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_step_pulse <= w_pulse_nxt;
         r_char_index <= w_idx_nxt;
         r_held       <= w_held_nxt;
      end
   end

   assign step_pulse = r_step_pulse;
   assign char_index = r_char_index;
   assign held       = r_held;

endmodule

// File: tb/tb_button_step_ctrl.sv
// Bench for button_step_ctrl: directed scenarios with literal expectations plus randomized
// button activity checked every cycle against a press-duration model.
module tb_button_step_ctrl;

   localparam int H = 8;
   localparam int R = 4;
   localparam int M = 16;

   logic       clk;
   logic       rst;
   logic       btn;
   logic       step_pulse;
   logic [3:0] char_index;
   logic       held;

   int n_checks = 0;
   int n_fail   = 0;

   button_step_ctrl #(
      .HOLD_CYCLES  (H),
      .REPEAT_CYCLES(R),
      .MSG_LEN      (M),
      .IDX_W        (4)
   ) dut (
      .clk        (clk),
      .reset      (rst),
      .btn_debounc(btn),
      .step_pulse (step_pulse),
      .char_index (char_index),
      .held       (held)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   // k = number of edges since the press edge (0 at the press edge itself)
   function automatic logic pulse_at(input int k);
      return (k == 0) || (k >= H && ((k - H) % R) == 0);
   endfunction

   // Model: locked until a release is seen after reset; otherwise outputs follow press duration.
   logic m_valid = 1'b0;
   logic m_locked;
   int   m_k;
   logic exp_pulse;
   logic exp_held;
   int   exp_idx;

   always @(posedge clk) begin
      if (rst) begin
         m_valid   <= 1'b1;
         m_locked  <= 1'b1;
         m_k       <= -1;
         exp_pulse <= 1'b0;
         exp_held  <= 1'b0;
         exp_idx   <= 0;
      end else if (m_locked) begin
         if (!btn) m_locked <= 1'b0;
         exp_pulse <= 1'b0;
         exp_held  <= 1'b0;
      end else if (btn) begin
         m_k       <= m_k + 1;
         exp_pulse <= pulse_at(m_k + 1);
         exp_held  <= (m_k + 1) >= H;
         if (pulse_at(m_k + 1)) exp_idx <= (exp_idx + 1) % M;
      end else begin
         m_k       <= -1;
         exp_pulse <= 1'b0;
         exp_held  <= 1'b0;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("model_step_pulse", int'(step_pulse), int'(exp_pulse));
         chk("model_held", int'(held), int'(exp_held));
         chk("model_char_index", int'(char_index), exp_idx);
      end
   end

   task automatic cyc(input logic b, input logic r);
      btn = b;
      rst = r;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int base;
      int run;
      logic lvl;
      btn = 1'b0;
      rst = 1'b1;
      #1;
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b1);
      chk("reset_pulse", int'(step_pulse), 0);
      chk("reset_index", int'(char_index), 0);
      chk("reset_held", int'(held), 0);

      // single short press
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b0);
      chk("press_pulse", int'(step_pulse), 1);
      chk("press_index", int'(char_index), 1);
      cyc(1'b1, 1'b0);
      chk("press_pulse_one_cycle", int'(step_pulse), 0);
      cyc(1'b1, 1'b0);
      chk("press_no_repeat", int'(step_pulse), 0);
      chk("press_held", int'(held), 0);
      cyc(1'b0, 1'b0);

      // long hold: pulses after E0, E8, E12, E16
      base = int'(char_index);
      for (int k = 0; k < 20; k++) begin
         cyc(1'b1, 1'b0);
         chk("hold_pulse", int'(step_pulse), (k == 0 || k == 8 || k == 12 || k == 16) ? 1 : 0);
         chk("hold_held", int'(held), (k >= 8) ? 1 : 0);
      end
      cyc(1'b0, 1'b0);
      chk("hold_release_held", int'(held), 0);
      chk("hold_release_pulse", int'(step_pulse), 0);
      chk("hold_index", int'(char_index), (base + 4) % M);

      // release one edge before the hold terminal count
      base = int'(char_index);
      for (int k = 0; k < 8; k++) cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      chk("early_release_pulse", int'(step_pulse), 0);
      chk("early_release_index", int'(char_index), (base + 1) % M);
      cyc(1'b1, 1'b0);
      chk("early_repress_pulse", int'(step_pulse), 1);
      cyc(1'b0, 1'b0);

      // wrap over 16 isolated presses
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b0);
      chk("wrap_start", int'(char_index), 0);
      for (int i = 0; i < M; i++) begin
         cyc(1'b1, 1'b0);
         chk("wrap_pulse", int'(step_pulse), 1);
         chk("wrap_index", int'(char_index), (i + 1) % M);
         cyc(1'b0, 1'b0);
      end

      // reset during repeat with button held
      for (int k = 0; k < 12; k++) cyc(1'b1, 1'b0);
      chk("pre_reset_held", int'(held), 1);
      cyc(1'b1, 1'b1);
      chk("mid_reset_pulse", int'(step_pulse), 0);
      chk("mid_reset_held", int'(held), 0);
      chk("mid_reset_index", int'(char_index), 0);
      for (int k = 0; k < 10; k++) begin
         cyc(1'b1, 1'b0);
         chk("locked_pulse", int'(step_pulse), 0);
      end
      cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b0);
      chk("after_lock_pulse", int'(step_pulse), 1);
      chk("after_lock_index", int'(char_index), 1);
      cyc(1'b0, 1'b0);

      // button held through reset and beyond
      cyc(1'b1, 1'b1);
      cyc(1'b1, 1'b1);
      for (int k = 0; k < 10; k++) begin
         cyc(1'b1, 1'b0);
         chk("held_thru_reset_pulse", int'(step_pulse), 0);
         chk("held_thru_reset_held", int'(held), 0);
      end
      cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b0);
      chk("unlock_pulse", int'(step_pulse), 1);
      chk("unlock_index", int'(char_index), 1);
      cyc(1'b1, 1'b0);
      chk("unlock_single", int'(step_pulse), 0);

      // randomized runs of button levels with occasional resets
      for (int n = 0; n < 300; n++) begin
         lvl = 1'($urandom_range(0, 1));
         run = (lvl && $urandom_range(0, 3) == 0) ? int'($urandom_range(8, 30))
                                                  : int'($urandom_range(1, 10));
         for (int c = 0; c < run; c++) begin
            cyc(lvl, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
         end
      end
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
